window3x3_gen: RTL

//  Streaming 3x3 neighbourhood generator that feeds the fuzzy edge-detection core (z0..z8 inputs).

---
 rtl/fuzzy_pkg.sv | 25 ++
 rtl/window3x3_gen_if.sv | 25 ++
 rtl/line_buffer.sv | 24 ++
 rtl/window3x3_gen.sv | 134 +++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// Shared definitions for the fuzzy edge-detection front end: default geometry,
// window FSM states and 3x3 window slot indices (row-major, top-left first).
package fuzzy_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  localparam int Z_TL = 0;
  localparam int Z_TM = 1;
  localparam int Z_TR = 2;
  localparam int Z_ML = 3;
  localparam int Z_MM = 4;
  localparam int Z_MR = 5;
  localparam int Z_BL = 6;
  localparam int Z_BM = 7;
  localparam int Z_BR = 8;

endpackage

// File: rtl/window3x3_gen_if.sv
// Pixel-in / window-out handshake bundle of the 3x3 window generator.
interface window3x3_gen_if
  import fuzzy_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
);
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_sof;
  logic             pix_ready;
  logic [PIX_W-1:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
  logic             win_valid;
  logic             win_ready;
  logic             win_last;

  modport slave (
    input  pix_in, pix_valid, pix_sof, win_ready,
    output pix_ready, z0, z1, z2, z3, z4, z5, z6, z7, z8, win_valid, win_last
  );

  modport master (
    output pix_in, pix_valid, pix_sof, win_ready,
    input  pix_ready, z0, z1, z2, z3, z4, z5, z6, z7, z8, win_valid, win_last
  );
endinterface

// File: rtl/line_buffer.sv
// One image line of pixel storage, addressed by column; the read returns the
// old contents of the addressed slot in the same cycle it is overwritten.
module line_buffer #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_data
);
  logic [PIX_W-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  // Line storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wr_data;
    end
  end
endmodule

// File: rtl/window3x3_gen.sv
// Raster-order pixel stream to 3x3 neighbourhood windows, one window per
// interior pixel, with valid/ready flow control on both sides.
module window3x3_gen
  import fuzzy_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic           clk,
  input  logic           rst,
  window3x3_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic [PIX_W-1:0] sh_q [9];
  logic [PIX_W-1:0] sh_d [9];
  logic [PIX_W-1:0] z_q  [9];
  logic [PIX_W-1:0] z_d  [9];
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic             pix_ready, frame_pix, is_last, load;
  logic [PIX_W-1:0] line0_rd, line1_rd;

  assign pix_ready = (state_q != ST_FLUSH) && (!win_valid_q || bus.win_ready);
  // In IDLE only a start-of-frame pixel enters the frame; others are swallowed.
  assign frame_pix = bus.pix_valid && pix_ready && (bus.pix_sof || (state_q == ST_STREAM));
  assign cur_col   = bus.pix_sof ? {CW{1'b0}} : col_q;
  assign cur_row   = bus.pix_sof ? {RW{1'b0}} : row_q;
  assign is_last   = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  assign load      = frame_pix && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_line0 (
    .clk(clk), .we(frame_pix), .addr(cur_col), .wr_data(bus.pix_in), .rd_data(line0_rd)
  );
  line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_line1 (
    .clk(clk), .we(frame_pix), .addr(cur_col), .wr_data(line0_rd), .rd_data(line1_rd)
  );

  // Next-state logic for counters, shift array, output window and FSM.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    sh_d        = sh_q;
    z_d         = z_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;

    if (frame_pix) begin
      for (int i = 0; i < 3; i++) begin
        sh_d[i*3]     = sh_q[i*3+1];
        sh_d[i*3 + 1] = sh_q[i*3+2];
      end
      sh_d[Z_TR] = line1_rd;
      sh_d[Z_MR] = line0_rd;
      sh_d[Z_BR] = bus.pix_in;
      if (is_last) begin
        col_d = {CW{1'b0}};
        row_d = {RW{1'b0}};
      end else if (cur_col == COL_LAST) begin
        col_d = {CW{1'b0}};
        row_d = cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end else begin
      sh_d = sh_q;
    end

    // A consume and a fresh load in the same cycle keeps win_valid high.
    if (load) begin
      z_d         = sh_d;
      win_valid_d = 1'b1;
      win_last_d  = is_last;
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end else begin
      win_valid_d = win_valid_q;
      win_last_d  = win_last_q;
    end

    case (state_q)
      ST_IDLE:   state_d = frame_pix ? ST_STREAM : ST_IDLE;
      ST_STREAM: state_d = (frame_pix && is_last) ? ST_FLUSH : ST_STREAM;
      ST_FLUSH:  state_d = (!win_valid_q || bus.win_ready) ? ST_IDLE : ST_FLUSH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= {CW{1'b0}};
      row_q       <= {RW{1'b0}};
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        sh_q[i] <= {PIX_W{1'b0}};
        z_q[i]  <= {PIX_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      sh_q        <= sh_d;
      z_q         <= z_d;
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;
  assign bus.z0 = z_q[Z_TL];
  assign bus.z1 = z_q[Z_TM];
  assign bus.z2 = z_q[Z_TR];
  assign bus.z3 = z_q[Z_ML];
  assign bus.z4 = z_q[Z_MM];
  assign bus.z5 = z_q[Z_MR];
  assign bus.z6 = z_q[Z_BL];
  assign bus.z7 = z_q[Z_BM];
  assign bus.z8 = z_q[Z_BR];
endmodule
